// File: rtl/readback_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : readback_pkg
//  Description : Shared constants, window lookup result type and the
//                per-window hit/offset helper for the register readback mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package readback_pkg;

    localparam int BYTE_W = 8;

    // Address compares run one bit wider than any supported ADDR_W (<= 16)
    // so that a window ending exactly at 2^ADDR_W never wraps to zero.
    localparam int CMP_W = 17;

    // Default status-source windows in the control-bus read space.
    localparam logic [7:0] VERSION_BASE = 8'h00;
    localparam logic [7:0] VERSION_LEN  = 8'd1;
    localparam logic [7:0] GATE_BASE    = 8'h20;
    localparam logic [7:0] GATE_LEN     = 8'd3;
    localparam logic [7:0] COUNTER_BASE = 8'h26;
    localparam logic [7:0] COUNTER_LEN  = 8'd10;
    localparam logic [7:0] DAC_BASE     = 8'h30;
    localparam logic [7:0] DAC_LEN      = 8'd2;
    localparam logic [7:0] PWM_BASE     = 8'h36;
    localparam logic [7:0] PWM_LEN      = 8'd11;

    typedef struct packed {
        logic             hit;
        logic [CMP_W-1:0] off;
    } win_res_t;

    // Hit test and byte offset for one window; callers zero-extend to CMP_W.
    function automatic win_res_t window_lookup(
        input logic [CMP_W-1:0] addr,
        input logic [CMP_W-1:0] base,
        input logic [CMP_W-1:0] len
    );
        win_res_t res;
        res.hit = (addr >= base) && (addr < (base + len));
        res.off = addr - base;
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/readback_window.sv
`default_nettype none
// ============================================================================
//  Module      : readback_window
//  Description : One source window of the readback mux: hit compare, byte
//                offset, little-endian byte select and (optionally) the
//                coherent snapshot latch with its busy flag.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                rd_req_i, rd_addr_i - read strobe and byte address
//                src_i             - live source value (MAX_BYTES bytes)
//                hit_o, byte_o     - window hit and selected byte
//                snap_busy_o       - snapshot holds unconsumed data
//  Revision    : 1.0 - initial release
// ============================================================================
module readback_window
    import readback_pkg::*;
#(
    parameter int              ADDR_W    = 8,
    parameter int              MAX_BYTES = 11,
    parameter logic [ADDR_W-1:0] BASE    = '0,
    parameter logic [7:0]      LEN       = 8'd1,
    parameter bit              SNAP      = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rd_req_i,
    input  logic [ADDR_W-1:0]             rd_addr_i,
    input  logic [MAX_BYTES*BYTE_W-1:0]   src_i,
    output logic                          hit_o,
    output logic [BYTE_W-1:0]             byte_o,
    output logic                          snap_busy_o
);

    localparam int SLICE_W = MAX_BYTES * BYTE_W;

    win_res_t               w_res;
    logic [SLICE_W-1:0]     snap_q;
    logic [SLICE_W-1:0]     snap_d;
    logic                   busy_q;
    logic                   busy_d;
    logic [BYTE_W-1:0]      live_byte;
    logic [BYTE_W-1:0]      snap_byte;
    logic                   capture;
    logic                   last_read;

    assign w_res = window_lookup(CMP_W'(rd_addr_i), CMP_W'(BASE), CMP_W'(LEN));

    // Explicit byte mux keeps out-of-range offsets (no hit) from indexing
    // past the slice.
    always_comb begin
        live_byte = '0;
        snap_byte = '0;
        for (int b = 0; b < MAX_BYTES; b++) begin
            if (w_res.off == CMP_W'(b)) begin
                live_byte = src_i[b*BYTE_W +: BYTE_W];
                snap_byte = snap_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

    assign capture   = SNAP && rd_req_i && w_res.hit && (w_res.off == '0);
    assign last_read = SNAP && rd_req_i && w_res.hit && !capture &&
                       (w_res.off == (CMP_W'(LEN) - CMP_W'(1)));

    always_comb begin
        snap_d = snap_q;
        busy_d = busy_q;
        if (capture) begin
            snap_d = src_i;
            // A one-byte window is fully consumed by its capture read.
            busy_d = (LEN != 8'd1);
        end else if (last_read) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            busy_q <= 1'b0;
        end else begin
            snap_q <= snap_d;
            busy_q <= busy_d;
        end
    end

    // Byte 0 of a snapshot window comes from the live value, which is the
    // same value being copied into the latch on that cycle.
    assign byte_o      = (SNAP && (w_res.off != '0)) ? snap_byte : live_byte;
    assign hit_o       = w_res.hit;
    assign snap_busy_o = busy_q;

endmodule
`default_nettype wire

// File: rtl/reg_readback_mux.sv
`default_nettype none
// ============================================================================
//  Module      : reg_readback_mux
//  Description : Registered register-readback selector. Maps N_SRC status
//                sources onto byte-addressed windows and returns one byte per
//                read request with a fixed one-cycle latency.
//  Ports       : clk, rst_n  - clock, async active-low reset
//                rd_req      - read strobe (one byte per asserted cycle)
//                rd_addr     - byte address
//                src_data    - live source values, source i in slice i
//                rd_data     - registered read byte
//                rd_valid    - one-cycle pulse qualifying rd_data/rd_err
//                rd_err      - address hit no window
//                snap_busy   - per-source unconsumed snapshot flag
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_readback_mux
    import readback_pkg::*;
#(
    parameter int                      ADDR_W    = 8,
    parameter int                      DATA_W    = BYTE_W,
    parameter int                      N_SRC     = 4,
    parameter int                      MAX_BYTES = 11,
    parameter logic [N_SRC*ADDR_W-1:0] SRC_BASE  = {PWM_BASE, COUNTER_BASE, GATE_BASE, VERSION_BASE},
    parameter logic [N_SRC*8-1:0]      SRC_LEN   = {PWM_LEN, COUNTER_LEN, GATE_LEN, VERSION_LEN},
    parameter logic [N_SRC-1:0]        SNAP_MASK = 4'b1100
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              rd_req,
    input  logic [ADDR_W-1:0]                 rd_addr,
    input  logic [N_SRC*MAX_BYTES*BYTE_W-1:0] src_data,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              rd_valid,
    output logic                              rd_err,
    output logic [N_SRC-1:0]                  snap_busy
);

    localparam int SLICE_W = MAX_BYTES * BYTE_W;

    logic [N_SRC-1:0]   win_hit;
    logic [BYTE_W-1:0]  win_byte [N_SRC];
    logic               any_hit;
    logic [BYTE_W-1:0]  sel_byte;

    logic [DATA_W-1:0]  rd_data_q;
    logic [DATA_W-1:0]  rd_data_d;
    logic               rd_valid_q;
    logic               rd_err_q;
    logic               rd_err_d;

    for (genvar i = 0; i < N_SRC; i++) begin : g_win
        readback_window #(
            .ADDR_W    (ADDR_W),
            .MAX_BYTES (MAX_BYTES),
            .BASE      (SRC_BASE[i*ADDR_W +: ADDR_W]),
            .LEN       (SRC_LEN[i*8 +: 8]),
            .SNAP      (SNAP_MASK[i])
        ) u_win (
            .clk         (clk),
            .rst_n       (rst_n),
            .rd_req_i    (rd_req),
            .rd_addr_i   (rd_addr),
            .src_i       (src_data[i*SLICE_W +: SLICE_W]),
            .hit_o       (win_hit[i]),
            .byte_o      (win_byte[i]),
            .snap_busy_o (snap_busy[i])
        );
    end

    // Scan from the top so the lowest-index hit is the last one written.
    always_comb begin
        any_hit  = 1'b0;
        sel_byte = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                any_hit  = 1'b1;
                sel_byte = win_byte[i];
            end
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        if (rd_req) begin
            rd_data_d = any_hit ? DATA_W'(sel_byte) : '0;
            rd_err_d  = !any_hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_req;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule
`default_nettype wire
